gpu_core_mc: RTL and testbench

Next-generation GPU shading core: a parametrised successor to the single-cycle core.
- Executes the same 16-bit opcode classes on a 2*BIT_WIDTH accumulator.
- Adds synchronous reset, an iterative (multi-cycle) signed/unsigned multiplier, unary accumulator ops and saturating stores.
- Adds a ready/done handshake so the sequencer can issue opcodes back-to-back without knowing op latency.
- Instantiated N times in the GPU array; all cores share `opcode`/`execute` and the global register bus.

---
 rtl/gpu_core_mc.sv | 184 ++++++++++++++++++
 tb/tb_gpu_core_mc.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_core_mc.sv
// gpu_core_mc: multi-cycle GPU shading core with a 2*BIT_WIDTH accumulator,
// an iterative signed/unsigned shift-add multiplier, unary accumulator ops,
// saturating stores and a ready/done issue handshake.
//
// Ports:
//   clk                 clock, all state on the rising edge
//   rst                 synchronous active-high reset
//   opcode[15:0]        instruction, sampled on an accepted edge
//   execute             issue strobe, accepted when ready=1
//   global_registers_in packed global registers, reg g at [BW*(g+1)-1:BW*g]
//   ready               core can accept an opcode this cycle
//   done                one-cycle pulse after an accepted op commits
//   accu                accumulator value
//
// state  | meaning
// S_IDLE | waiting for an opcode; single-cycle ops commit on the accept edge
// S_MUL  | shift-add multiply in progress, one multiplier bit per cycle
module gpu_core_mc #(
    parameter int CORE_ID        = 0,
    parameter int BIT_WIDTH      = 8,
    parameter int NR_LOCAL_REGS  = 8,
    parameter int NR_GLOBAL_REGS = 9
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [15:0]                         opcode,
    input  logic                                execute,
    input  logic [NR_GLOBAL_REGS*BIT_WIDTH-1:0] global_registers_in,
    output logic                                ready,
    output logic                                done,
    output logic [2*BIT_WIDTH-1:0]              accu
);
    localparam int AW = 2 * BIT_WIDTH;
    localparam int CW = $clog2(BIT_WIDTH);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic                   done_q, done_d;
    logic [BIT_WIDTH-1:0]   regs_q [NR_LOCAL_REGS];
    logic [BIT_WIDTH-1:0]   regs_d [NR_LOCAL_REGS];
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [AW-1:0]          mcand_q, mcand_d;
    logic [BIT_WIDTH-1:0]   mplier_q, mplier_d;
    logic [AW-1:0]          prod_q, prod_d;
    logic                   signed_q, signed_d;

    logic [BIT_WIDTH-1:0]   rmap [32];
    logic [BIT_WIDTH-1:0]   rd_a, rd_b, imm, store_val;
    logic [AW-1:0]          ext_a, ext_b, in0, in1, neg, addend, psum;
    logic [BIT_WIDTH:0]     sat_hi;
    logic                   fits, last, wr_en;
    logic [BIT_WIDTH-1:0]   wr_val;

    // Full 5-bit read map; unmapped indices stay zero.
    always_comb begin
        for (int i = 0; i < 32; i++) rmap[i] = '0;
        for (int i = 0; i < NR_LOCAL_REGS; i++) rmap[i] = regs_q[i];
        rmap[15] = BIT_WIDTH'(CORE_ID);
        for (int g = 0; g < NR_GLOBAL_REGS; g++)
            rmap[16+g] = global_registers_in[g*BIT_WIDTH +: BIT_WIDTH];
    end

    always_comb begin
        rd_a  = rmap[opcode[13:9]];
        rd_b  = rmap[{1'b0, opcode[8:5]}];
        ext_a = {{BIT_WIDTH{rd_a[BIT_WIDTH-1]}}, rd_a};
        ext_b = {{BIT_WIDTH{rd_b[BIT_WIDTH-1]}}, rd_b};
        imm   = BIT_WIDTH'($signed(opcode[7:0]));
        in0   = opcode[2] ? acc_q : ext_a;
        in1   = opcode[3] ? acc_q : ext_b;
        neg   = '0 - acc_q;
        // Saturation only needed when the bits above the store width are not
        // a pure sign extension of the stored MSB.
        sat_hi    = acc_q[AW-1:BIT_WIDTH-1];
        fits      = (&sat_hi) | ~(|sat_hi);
        store_val = acc_q[BIT_WIDTH-1:0];
        if (opcode[7] && !fits)
            store_val = {acc_q[AW-1], {(BIT_WIDTH-1){~acc_q[AW-1]}}};
        // Signed multiply: the multiplier MSB carries negative weight, so the
        // last partial product is subtracted instead of added.
        addend = mplier_q[0] ? mcand_q : '0;
        last   = (cnt_q == CW'(BIT_WIDTH - 1));
        psum   = (last && signed_q) ? prod_q - addend : prod_q + addend;
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        signed_d = signed_q;
        wr_en    = 1'b0;
        wr_val   = imm;
        regs_d   = regs_q;
        unique case (state_q)
            S_IDLE: begin
                if (execute) begin
                    unique case (opcode[15:14])
                        2'b00: begin
                            wr_en  = 1'b1;
                            done_d = 1'b1;
                        end
                        2'b01: begin
                            if (!opcode[1]) begin
                                acc_d  = opcode[0] ? in0 - in1 : in0 + in1;
                                done_d = 1'b1;
                            end else begin
                                mcand_d  = opcode[4] ? ext_a
                                                     : {{BIT_WIDTH{1'b0}}, rd_a};
                                mplier_d = rd_b;
                                prod_d   = '0;
                                cnt_d    = '0;
                                signed_d = opcode[4];
                                state_d  = S_MUL;
                            end
                        end
                        2'b10: begin
                            case (opcode[3:0])
                                4'd0:    acc_d = '0;
                                4'd1:    acc_d = neg;
                                4'd2:    acc_d = {acc_q[AW-2:0], 1'b0};
                                4'd3:    acc_d = {acc_q[AW-1], acc_q[AW-1:1]};
                                4'd4:    acc_d = acc_q[AW-1] ? neg : acc_q;
                                default: acc_d = acc_q;
                            endcase
                            done_d = 1'b1;
                        end
                        2'b11: begin
                            wr_en  = opcode[8];
                            wr_val = store_val;
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL: begin
                prod_d   = psum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (last) begin
                    acc_d   = psum;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
        for (int i = 0; i < NR_LOCAL_REGS; i++)
            if (wr_en && opcode[13:9] == 5'(i)) regs_d[i] = wr_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            signed_q <= 1'b0;
            for (int i = 0; i < NR_LOCAL_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            signed_q <= signed_d;
            regs_q   <= regs_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign done  = done_q;
    assign accu  = acc_q;
endmodule

// File: tb/tb_gpu_core_mc.sv
module tb_gpu_core_mc;
    localparam int BW  = 8;
    localparam int NL  = 8;
    localparam int NG  = 9;
    localparam logic [7:0] CID = 8'h3C;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   opcode;
    logic          execute;
    logic [NG*BW-1:0] gbus;
    logic          ready, done;
    logic [2*BW-1:0] accu;

    logic [7:0]    glob [NG];
    logic [7:0]    m_regs [NL];
    logic [15:0]   m_acc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb
        for (int g = 0; g < NG; g++) gbus[g*BW +: BW] = glob[g];

    gpu_core_mc #(.CORE_ID(int'(CID)), .BIT_WIDTH(BW), .NR_LOCAL_REGS(NL),
                  .NR_GLOBAL_REGS(NG)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .execute(execute),
        .global_registers_in(gbus), .ready(ready), .done(done), .accu(accu));

    typedef struct {
        logic [15:0] op;
        logic [15:0] exp_acc;
        string       name;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] f_ldi(input int d, input logic [7:0] v);
        return {2'b00, 5'(d), 1'b0, v};
    endfunction
    function automatic logic [15:0] f_two(input int a, input int b, input logic [4:0] f);
        return {2'b01, 5'(a), 4'(b), f};
    endfunction
    function automatic logic [15:0] f_un(input logic [3:0] f);
        return {2'b10, 10'd0, f};
    endfunction
    function automatic logic [15:0] f_st(input int d, input logic sat);
        return {2'b11, 5'(d), 1'b1, sat, 7'd0};
    endfunction
    function automatic logic [15:0] f_rd(input int r);
        return f_two(r, 0, 5'b01000);
    endfunction

    // Behavioural reference: integer arithmetic on register contents.
    function automatic logic [7:0] m_rd(input int idx);
        if (idx < NL) return m_regs[idx];
        if (idx == 15) return CID;
        if (idx >= 16 && idx < 16 + NG) return glob[idx-16];
        return 8'h00;
    endfunction

    task automatic m_step(input logic [15:0] op, output logic [15:0] exp);
        int d, v, x0, x1;
        logic [7:0] ra, rb;
        d  = int'(op[13:9]);
        ra = m_rd(int'(op[13:9]));
        rb = m_rd(int'(op[8:5]));
        case (op[15:14])
            2'b00: if (d < NL) m_regs[d] = op[7:0];
            2'b01: begin
                if (op[1]) begin
                    if (op[4]) v = int'($signed(ra)) * int'($signed(rb));
                    else       v = int'(ra) * int'(rb);
                end else begin
                    x0 = op[2] ? int'($signed(m_acc)) : int'($signed(ra));
                    x1 = op[3] ? int'($signed(m_acc)) : int'($signed(rb));
                    v  = op[0] ? x0 - x1 : x0 + x1;
                end
                m_acc = v[15:0];
            end
            2'b10: begin
                v = int'($signed(m_acc));
                case (op[3:0])
                    4'd0: v = 0;
                    4'd1: v = -v;
                    4'd2: v = v * 2;
                    4'd3: v = v >>> 1;
                    4'd4: v = (v < 0) ? -v : v;
                    default: ;
                endcase
                m_acc = v[15:0];
            end
            default: if (op[8]) begin
                v = int'($signed(m_acc));
                if (op[7]) begin
                    if (v > 127)  v = 127;
                    if (v < -128) v = -128;
                end
                if (d < NL) m_regs[d] = v[7:0];
            end
        endcase
        exp = m_acc;
    endtask

    // Issue one op at the current falling edge and check its completion.
    // While a multiply is busy, random ops are strobed (must be ignored) and,
    // optionally, the global registers are scrambled.
    task automatic run_op(input logic [15:0] op, input logic [15:0] exp,
                          input string nm, input bit scramble);
        int busy;
        opcode  = op;
        execute = 1'b1;
        @(negedge clk);
        if (op[15:14] == 2'b01 && op[1]) begin
            busy = 0;
            while (ready !== 1'b1 && busy < 40) begin
                busy++;
                opcode  = 16'($urandom);
                execute = 1'b1;
                if (scramble) glob[$urandom_range(0, NG-1)] = 8'($urandom);
                @(negedge clk);
            end
            chk({nm, "_busy"}, busy, BW);
        end
        execute = 1'b0;
        chk({nm, "_accu"}, accu, exp);
        chk({nm, "_done"}, done, 1'b1);
        chk({nm, "_ready"}, ready, 1'b1);
    endtask

    initial begin
        logic [15:0] e, op;
        int hits;
        rst = 1'b1; execute = 1'b0; opcode = '0;
        for (int g = 0; g < NG; g++) glob[g] = 8'(g * 17 + 3);
        glob[0] = 8'h9A;
        repeat (2) @(negedge clk);
        chk("rst_accu", accu, 16'h0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;

        tbl.push_back('{f_ldi(0, 8'h7F), 16'h0000, "ldi_r0"});
        tbl.push_back('{f_ldi(1, 8'h03), 16'h0000, "ldi_r1"});
        tbl.push_back('{f_two(0, 1, 5'b00000), 16'h0082, "add"});
        tbl.push_back('{f_ldi(0, 8'hFF), 16'h0082, "ldi_r0_ff"});
        tbl.push_back('{f_ldi(1, 8'hFF), 16'h0082, "ldi_r1_ff"});
        tbl.push_back('{f_two(0, 1, 5'b00010), 16'hFE01, "umul_ff"});
        tbl.push_back('{f_ldi(1, 8'h05), 16'hFE01, "ldi_r1_5"});
        tbl.push_back('{f_two(0, 1, 5'b10010), 16'hFFFB, "smul_m1x5"});
        tbl.push_back('{f_ldi(0, 8'h80), 16'hFFFB, "ldi_r0_80"});
        tbl.push_back('{f_ldi(1, 8'h80), 16'hFFFB, "ldi_r1_80"});
        tbl.push_back('{f_two(0, 1, 5'b10010), 16'h4000, "smul_80x80"});
        tbl.push_back('{f_un(4'd2), 16'h8000, "shl"});
        tbl.push_back('{f_un(4'd4), 16'h8000, "abs_min"});
        tbl.push_back('{f_un(4'd7), 16'h8000, "unary_nop"});
        tbl.push_back('{16'hC000, 16'h8000, "misc_nop"});
        tbl.push_back('{f_ldi(4, 8'h12), 16'h8000, "ldi_r4"});
        tbl.push_back('{f_ldi(5, 8'h10), 16'h8000, "ldi_r5"});
        tbl.push_back('{f_two(4, 5, 5'b00001), 16'h0002, "sub"});
        tbl.push_back('{f_two(4, 5, 5'b00010), 16'h0120, "umul_120"});
        tbl.push_back('{f_ldi(6, 8'h03), 16'h0120, "ldi_r6"});
        tbl.push_back('{f_two(6, 0, 5'b01000), 16'h0123, "add_acc"});
        tbl.push_back('{f_st(2, 1'b1), 16'h0123, "st_sat"});
        tbl.push_back('{f_un(4'd0), 16'h0000, "clear"});
        tbl.push_back('{f_rd(2), 16'h007F, "rd_r2_sat"});
        tbl.push_back('{f_two(4, 5, 5'b00010), 16'h0120, "umul_120b"});
        tbl.push_back('{f_two(6, 0, 5'b01000), 16'h0123, "add_acc_b"});
        tbl.push_back('{f_st(2, 1'b0), 16'h0123, "st_nosat"});
        tbl.push_back('{f_st(12, 1'b0), 16'h0123, "st_r12"});
        tbl.push_back('{f_un(4'd0), 16'h0000, "clear"});
        tbl.push_back('{f_rd(2), 16'h0023, "rd_r2"});
        tbl.push_back('{f_two(12, 0, 5'b01000), 16'h0023, "rd_r12"});
        tbl.push_back('{f_un(4'd0), 16'h0000, "clear"});
        tbl.push_back('{f_rd(15), 16'h003C, "rd_core_id"});
        tbl.push_back('{f_un(4'd0), 16'h0000, "clear"});
        tbl.push_back('{f_rd(16), 16'hFF9A, "rd_glob0"});
        tbl.push_back('{f_un(4'd0), 16'h0000, "clear"});
        tbl.push_back('{f_ldi(7, 8'h01), 16'h0000, "ldi_r7"});
        tbl.push_back('{f_rd(7), 16'h0001, "rd_r7"});
        tbl.push_back('{f_un(4'd1), 16'hFFFF, "negate"});
        tbl.push_back('{f_un(4'd2), 16'hFFFE, "shl_neg"});
        tbl.push_back('{f_un(4'd3), 16'hFFFF, "asr"});

        foreach (tbl[i]) run_op(tbl[i].op, tbl[i].exp_acc, tbl[i].name, 1'b0);

        // done is a single-cycle pulse.
        @(negedge clk);
        chk("done_pulse_end", done, 1'b0);
        chk("idle_ready", ready, 1'b1);

        // Reset during the fourth cycle of a multiply aborts it.
        opcode = f_two(0, 1, 5'b00010); execute = 1'b1;
        @(negedge clk);
        execute = 1'b0;
        chk("mul_started", ready, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmul_accu", accu, 16'h0);
        chk("rstmul_ready", ready, 1'b1);
        chk("rstmul_done", done, 1'b0);
        hits = 0;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0 || accu !== 16'h0) hits++;
        end
        chk("rstmul_no_commit", hits, 0);
        for (int r = 0; r < NL; r++) begin
            run_op(f_un(4'd0), 16'h0, "clear", 1'b0);
            run_op(f_rd(r), 16'h0, $sformatf("rst_reg%0d", r), 1'b0);
        end

        // Randomized ops against the reference model (state is all zero now).
        for (int r = 0; r < NL; r++) m_regs[r] = 8'h00;
        m_acc = 16'h0;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) glob[$urandom_range(0, NG-1)] = 8'($urandom);
            op = 16'($urandom);
            if ($urandom_range(0, 3) != 0) op[13:9] = 5'($urandom_range(0, 7));
            m_step(op, e);
            run_op(op, e, $sformatf("rnd%0d_op%04h", n, op), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
